// File: rtl/instr_encoder.sv
// RV32I instruction word assembler: packs opcode/register/funct fields and a full
// 32-bit immediate into one instruction, with a registered valid/ready output stage.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SH = 3'd6;

  logic                out_valid_q;
  logic [31:0]         instr_q, instr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, out_addr_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic                accept, xfer;

  // A value fits a signed N-bit field when bits [31:N-1] are all equal.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    instr_d = '0;
    err_d   = 1'b0;
    case (fmt)
      F_R:  instr_d = {funct7, rs2, rs1, funct3, rd, opcode};
      F_I: begin
        instr_d = {imm[11:0], rs1, funct3, rd, opcode};
        err_d   = ~fits12;
      end
      F_S: begin
        instr_d = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err_d   = ~fits12;
      end
      F_B: begin
        instr_d = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err_d   = ~fits13 | imm[0];
      end
      F_U: begin
        instr_d = {imm[31:12], rd, opcode};
        err_d   = |imm[11:0];
      end
      F_J: begin
        instr_d = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err_d   = ~fits21 | imm[0];
      end
      F_SH: begin
        instr_d = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        err_d   = |imm[31:5];
      end
      default: begin
        instr_d = '0;
        err_d   = 1'b1;
      end
    endcase
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      out_addr_q  <= BASE_ADDR;
      addr_q      <= BASE_ADDR;
      err_cnt_q   <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        instr_q     <= instr_d;
        err_q       <= err_d;
        out_addr_q  <= clear ? BASE_ADDR : addr_q;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end

      // clear wins; an accept in the clear cycle takes BASE_ADDR, so step past it.
      if (clear)
        addr_q <= accept ? BASE_ADDR + ADDR_W'(4) : BASE_ADDR;
      else if (accept)
        addr_q <= addr_q + ADDR_W'(4);

      if (clear)
        err_cnt_q <= '0;
      else if (xfer && err_q && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_addr  = out_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate generator: assembles RV32I fields (opcode, registers, funct3/funct7, full 32-bit immediate) into a 32-bit instruction word.
- Used by the accelerator/program loader to emit instruction streams into instruction memory.
- One registered pipeline stage with valid/ready on both sides.
- Adds an auto-incrementing write address, an immediate range check and a saturating error counter.

Parameters:
- ADDR_W, 32, width of the generated write address.
- BASE_ADDR, 32'h0000_0000, address loaded at reset and on clear.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous: reload address to BASE_ADDR, zero err_cnt.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept.
- fmt  input  3  layout: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift; 7 is illegal.
- opcode  input  7  placed verbatim in bits [6:0].
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  bits [14:12].
- funct7  input  7  bits [31:25] for R and I-shift.
- imm  input  32  full byte-offset/value immediate.
- out_valid  output  1  word valid.
- out_ready  input  1  consumer accepts.
- out_instr  output  32  encoded word.
- out_addr  output  ADDR_W  address for out_instr.
- out_err  output  1  immediate out of range or illegal fmt.
- err_cnt  output  ERRCNT_W  saturating count of emitted words with out_err=1.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_err=0.
  - Internal address and out_addr = BASE_ADDR.
  - err_cnt=0.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: 1 cycle. The accepted request appears on out_instr/out_err with out_valid=1 at the next edge. Full throughput (one word per cycle) when out_ready is held high.
- Output register holds out_instr/out_addr/out_err stable while out_valid && !out_ready.
- Simultaneous accept and output transfer: the register loads the new word and out_valid stays 1.
- out_valid clears only on a transfer with no new accept.
- Address:
  - Internal address register is captured into out_addr on each accept.
  - It then increments by 4 and wraps modulo 2^ADDR_W, e.g. 0xFFFFFFFC -> 0x00000000.
- Encoding layouts (bits [6:0] = opcode in all cases):
  - R: funct7 | rs2 | rs1 | funct3 | rd.
  - I: imm[11:0] | rs1 | funct3 | rd.
  - I-shift: funct7 | imm[4:0] | rs1 | funct3 | rd.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0].
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11].
  - U: imm[31:12] | rd.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd.
- Range checks (set out_err; the word is still encoded from truncated bits):
  - I, S: imm not in [-2048, 2047].
  - B: imm not in [-4096, 4094], or imm[0]=1.
  - J: imm not in [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0] != 0.
  - I-shift: imm > 31 (unsigned).
  - R: imm ignored, never an error.
  - fmt=7: out_instr=0, out_err=1.
- err_cnt:
  - Increments on each output transfer carrying out_err=1.
  - Saturates at all-ones.
- clear:
  - Address and err_cnt reload on the edge.
  - clear has priority over the increment.
  - A word already in the output register keeps its out_addr.
  - A request accepted in the same cycle as clear gets BASE_ADDR, and the internal address becomes BASE_ADDR+4.
- Reset mid-stream: the pending word is discarded and out_valid drops immediately (asynchronous).

Test Plan:
- Single encodes, each checked against its expected word:
  - fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> 0x00500093, out_err=0, out_addr=BASE_ADDR.
  - fmt=2, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
  - fmt=3, op=0x63, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
- fmt=5, op=0x6F, rd=1, imm=0x800 -> 0x001000EF.
- fmt=4, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Streaming with out_ready=1: 4 back-to-back requests -> 4 words on consecutive cycles, out_addr 0,4,8,12.
- Backpressure: hold out_ready=0 with a word pending -> in_ready=0, outputs stable for 5 cycles; release -> transfer and next accept in the same cycle.
- Errors:
  - fmt=1, imm=2048 -> out_err=1, err_cnt 0->1.
  - fmt=3, imm=3 -> out_err=1.
  - fmt=7 -> out_instr=0, out_err=1.
  - 300 error words -> err_cnt saturates at 255.
- clear and wrap:
  - clear pulse resets out_addr to BASE_ADDR and err_cnt to 0.
  - With ADDR_W=4 and BASE_ADDR=12, two accepts give out_addr 12 then 0.
- Asynchronous reset asserted while out_valid=1 -> out_valid=0 immediately, no spurious transfer after release.
